mem_ctrl: RTL and testbench

Memory controller between the core and the single-port byte-wide RAM/IO bus. Serialises three requesters (committed stores from the ROB, loads from the LSB, instruction fetch from IFetch) into byte transactions. Loads and stores of 1/2/4 bytes are supported, with sign or zero extension on loads. Returns one-cycle completion pulses, `mem_valid`/`mem_res` for LSB loads and `finish_store` for stores; the LSB consumes both directly.

---
 rtl/mem_ctrl_pkg.sv | 43 ++++
 rtl/mem_extend.sv | 38 +++
 rtl/mem_ctrl.sv | 168 ++++++++++++++++
 tb/tb_mem_ctrl.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory controller.
// Holds the load/store op codes, the IO region tag, the controller state and
// transaction-kind encodings, and the op -> byte-count decode.
package mem_ctrl_pkg;

  typedef enum logic [5:0] {
    OP_NONE = 6'd0,
    OP_LB   = 6'd1,
    OP_LH   = 6'd2,
    OP_LW   = 6'd3,
    OP_LBU  = 6'd4,
    OP_LHU  = 6'd5,
    OP_SB   = 6'd6,
    OP_SH   = 6'd7,
    OP_SW   = 6'd8
  } op_t;

  // Stores whose address bits [17:16] match this go to the UART.
  localparam logic [1:0] IO_ADDR_HI = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    K_LOAD  = 2'd0,
    K_FETCH = 2'd1,
    K_STORE = 2'd2
  } kind_t;

  // Number of bytes moved by an op; fetches use OP_LW.
  function automatic logic [2:0] op_size(input op_t op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 3'd1;
      OP_LH, OP_LHU, OP_SH: return 3'd2;
      default:              return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_extend.sv
// Combinational result assembly for reads.
// Ports:
//   op     : load op of the transaction (OP_LW for fetches)
//   prefix : earlier bytes of the read, oldest byte in the lowest lane of the
//            occupied top lanes (bytes shift in from the top)
//   last   : final byte, taken straight from the RAM data bus
//   data   : little-endian word, sign or zero extended according to op
module mem_extend
  import mem_ctrl_pkg::*;
(
  input  op_t         op,
  input  logic [23:0] prefix,
  input  logic [7:0]  last,
  output logic [31:0] data
);

  logic [31:0] raw;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    raw = {24'b0, last};
    case (op_size(op))
      3'd2:    raw = {16'b0, last, prefix[23:16]};
      3'd4:    raw = {last, prefix};
      default: ;
    endcase

    // Unsigned loads are already zero extended by the merge above.
    data = raw;
    case (op)
      OP_LB:   data = {{24{raw[7]}}, raw[7:0]};
      OP_LH:   data = {{16{raw[15]}}, raw[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_ctrl.sv
// Memory controller: serialises committed stores, LSB loads and instruction
// fetches onto the single-port byte-wide RAM/IO bus.
// Ports:
//   clk, rst (sync, active high), rdy (low freezes everything), rollback
//   lsb_req/lsb_op/lsb_addr  -> mem_valid/mem_res      : loads
//   st_req/st_op/st_addr/st_data -> finish_store       : committed stores
//   if_req/if_addr           -> if_valid/if_inst       : fetches
//   mem_din, mem_dout, mem_a, mem_wr                    : RAM/IO byte bus
//   io_buffer_full                                      : UART back-pressure
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rollback,
  input  logic        lsb_req,
  input  logic [5:0]  lsb_op,
  input  logic [31:0] lsb_addr,
  output logic        mem_valid,
  output logic [31:0] mem_res,
  input  logic        st_req,
  input  logic [5:0]  st_op,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        finish_store,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_valid,
  output logic [31:0] if_inst,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  state_t      state;
  kind_t       kind;
  op_t         op;
  logic [2:0]  size;
  logic [2:0]  cnt;      // edges since acceptance, starting at 1
  logic [23:0] rbuf;     // read bytes captured so far
  logic [23:0] wbuf;     // store bytes still to be sent
  logic        load_done;
  logic        fetch_done;
  logic [31:0] ext_data;

  op_t  st_op_e;
  op_t  lsb_op_e;
  logic st_blocked;

  assign st_op_e  = op_t'(st_op);
  assign lsb_op_e = op_t'(lsb_op);

  // A blocked IO store also stalls the lower requesters to preserve order.
  assign st_blocked = st_req && (st_addr[17:16] == IO_ADDR_HI) && io_buffer_full;

  mem_extend u_extend (
    .op     (op),
    .prefix (rbuf),
    .last   (mem_din),
    .data   (ext_data)
  );

  // A flush arriving while a load/fetch pulse is up cancels the pulse.
  assign mem_valid = load_done  & ~rollback;
  assign if_valid  = fetch_done & ~rollback;

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      kind         <= K_LOAD;
      op           <= OP_NONE;
      size         <= 3'd0;
      cnt          <= 3'd0;
      rbuf         <= 24'b0;
      wbuf         <= 24'b0;
      mem_a        <= 32'b0;
      mem_dout     <= 8'b0;
      mem_wr       <= 1'b0;
      load_done    <= 1'b0;
      fetch_done   <= 1'b0;
      finish_store <= 1'b0;
      mem_res      <= 32'b0;
      if_inst      <= 32'b0;
    end else if (rdy) begin
      load_done    <= 1'b0;
      fetch_done   <= 1'b0;
      finish_store <= 1'b0;

      case (state)
        ST_IDLE: begin
          cnt <= 3'd1;
          if (st_req) begin
            if (!st_blocked) begin
              state    <= ST_WRITE;
              kind     <= K_STORE;
              op       <= st_op_e;
              size     <= op_size(st_op_e);
              mem_a    <= st_addr;
              mem_dout <= st_data[7:0];
              wbuf     <= st_data[31:8];
              mem_wr   <= 1'b1;
            end
          end else if (!rollback && lsb_req) begin
            state  <= ST_READ;
            kind   <= K_LOAD;
            op     <= lsb_op_e;
            size   <= op_size(lsb_op_e);
            mem_a  <= lsb_addr;
            mem_wr <= 1'b0;
          end else if (!rollback && if_req) begin
            state  <= ST_READ;
            kind   <= K_FETCH;
            op     <= OP_LW;
            size   <= 3'd4;
            mem_a  <= if_addr;
            mem_wr <= 1'b0;
          end
        end

        ST_WRITE: begin
          // Committed stores ignore rollback.
          if (cnt == size) begin
            mem_wr       <= 1'b0;
            finish_store <= 1'b1;
            state        <= ST_DONE;
          end else begin
            mem_a    <= mem_a + 32'd1;
            mem_dout <= wbuf[7:0];
            wbuf     <= {8'b0, wbuf[23:8]};
            cnt      <= cnt + 3'd1;
          end
        end

        ST_READ: begin
          if (rollback) begin
            mem_wr <= 1'b0;
            state  <= ST_IDLE;
          end else if (cnt == size + 3'd1) begin
            // RAM returns byte i two edges after its address; the final byte
            // is merged from mem_din without an extra capture stage.
            if (kind == K_FETCH) begin
              if_inst    <= ext_data;
              fetch_done <= 1'b1;
            end else begin
              mem_res   <= ext_data;
              load_done <= 1'b1;
            end
            state <= ST_DONE;
          end else begin
            if (cnt < size) mem_a <= mem_a + 32'd1;
            if (cnt >= 3'd2) rbuf <= {mem_din, rbuf[23:8]};
            cnt <= cnt + 3'd1;
          end
        end

        ST_DONE: state <= ST_IDLE;

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: a byte RAM with registered address sits on
// the bus, and expected results come from a byte-array reference of memory.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst, rdy, rollback;
  logic        lsb_req;
  logic [5:0]  lsb_op;
  logic [31:0] lsb_addr;
  logic        mem_valid;
  logic [31:0] mem_res;
  logic        st_req;
  logic [5:0]  st_op;
  logic [31:0] st_addr, st_data;
  logic        finish_store;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .lsb_req(lsb_req), .lsb_op(lsb_op), .lsb_addr(lsb_addr),
    .mem_valid(mem_valid), .mem_res(mem_res),
    .st_req(st_req), .st_op(st_op), .st_addr(st_addr), .st_data(st_data),
    .finish_store(finish_store),
    .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_inst(if_inst),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  // Bus-side RAM (64 KiB, address bits [15:0]) plus an IO sink.
  logic [7:0]  ram     [65536];
  logic [7:0]  ref_mem [65536];
  logic [31:0] addr_q = 32'b0;
  logic [39:0] wr_log [$];
  logic [7:0]  io_log [$];

  always @(posedge clk) begin
    if (rdy) begin
      if (mem_wr) begin
        wr_log.push_back({mem_a, mem_dout});
        if (mem_a[17:16] == 2'b11) io_log.push_back(mem_dout);
        else ram[mem_a[15:0]] <= mem_dout;
      end
      addr_q <= mem_a;
    end
  end
  assign mem_din = ram[addr_q[15:0]];

  function automatic int nbytes(input op_t op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 1;
      OP_LH, OP_LHU, OP_SH: return 2;
      default:              return 4;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input op_t op, input logic [31:0] addr);
    longint v = 0;
    logic [31:0] a;
    for (int i = 0; i < nbytes(op); i++) begin
      a = addr + 32'(i);
      v += longint'(ref_mem[a[15:0]]) << (8 * i);
    end
    if (op == OP_LB && v >= 128)   v -= 256;
    if (op == OP_LH && v >= 32768) v -= 65536;
    return v[31:0];
  endfunction

  function automatic void poke(input logic [31:0] a, input logic [7:0] b);
    ram[a[15:0]]     = b;
    ref_mem[a[15:0]] = b;
  endfunction

  task automatic run_load(input op_t op, input logic [31:0] addr, input int stall_at,
                          output logic [31:0] res);
    logic [31:0] exp, a_hold;
    int n, cyc, wr0, extra;
    bit got;
    n = nbytes(op); exp = ref_load(op, addr); wr0 = wr_log.size();
    extra = (stall_at > 0) ? 3 : 0;
    a_hold = 32'b0;
    @(negedge clk); lsb_req = 1'b1; lsb_op = op; lsb_addr = addr;
    got = 1'b0; cyc = 0;
    while (!got && cyc < 40) begin
      @(posedge clk); #1; cyc++;
      if (mem_valid) got = 1'b1;
      if (stall_at > 0 && cyc == stall_at) begin rdy = 1'b0; a_hold = mem_a; end
      if (stall_at > 0 && cyc > stall_at && cyc < stall_at + 3) begin
        vectors++;
        if (mem_a !== a_hold) begin
          miscompares++; $display("FAIL load_rdy_hold: mem_a=%h expected %h", mem_a, a_hold);
        end
      end
      if (stall_at > 0 && cyc == stall_at + 3) rdy = 1'b1;
    end
    lsb_req = 1'b0; res = mem_res;
    vectors++;
    if (!got) begin
      miscompares++; $display("FAIL load_timeout: op=%0d addr=%h no mem_valid", op, addr);
    end else begin
      vectors++;
      if (mem_res !== exp) begin
        miscompares++; $display("FAIL load_data: op=%0d addr=%h got %h expected %h", op, addr, mem_res, exp);
      end
      vectors++;
      if (cyc - 1 != n + 1 + extra) begin
        miscompares++; $display("FAIL load_latency: got %0d edges expected %0d", cyc - 1, n + 1 + extra);
      end
      vectors++;
      if (wr_log.size() != wr0) begin
        miscompares++; $display("FAIL load_bus_write: %0d writes during load, expected 0", wr_log.size() - wr0);
      end
      @(posedge clk); #1;
      vectors++;
      if (mem_valid !== 1'b0) begin
        miscompares++; $display("FAIL load_pulse_width: mem_valid=%b expected 0", mem_valid);
      end
    end
  endtask

  task automatic run_fetch(input logic [31:0] addr, output logic [31:0] res);
    logic [31:0] exp;
    int cyc, wr0;
    bit got;
    exp = ref_load(OP_LW, addr); wr0 = wr_log.size();
    @(negedge clk); if_req = 1'b1; if_addr = addr;
    got = 1'b0; cyc = 0;
    while (!got && cyc < 40) begin
      @(posedge clk); #1; cyc++;
      if (if_valid) got = 1'b1;
    end
    if_req = 1'b0; res = if_inst;
    vectors++;
    if (!got) begin
      miscompares++; $display("FAIL fetch_timeout: addr=%h no if_valid", addr);
    end else begin
      vectors++;
      if (if_inst !== exp) begin
        miscompares++; $display("FAIL fetch_data: addr=%h got %h expected %h", addr, if_inst, exp);
      end
      vectors++;
      if (cyc - 1 != 5) begin
        miscompares++; $display("FAIL fetch_latency: got %0d edges expected 5", cyc - 1);
      end
      vectors++;
      if (wr_log.size() != wr0) begin
        miscompares++; $display("FAIL fetch_bus_write: %0d writes during fetch, expected 0", wr_log.size() - wr0);
      end
      @(posedge clk); #1;
      vectors++;
      if (if_valid !== 1'b0) begin
        miscompares++; $display("FAIL fetch_pulse_width: if_valid=%b expected 0", if_valid);
      end
    end
  endtask

  task automatic run_store(input op_t op, input logic [31:0] addr, input logic [31:0] data,
                           input int rb_at);
    int n, cyc, base;
    bit got;
    logic [31:0] a;
    n = nbytes(op); base = wr_log.size();
    @(negedge clk); st_req = 1'b1; st_op = op; st_addr = addr; st_data = data;
    got = 1'b0; cyc = 0;
    while (!got && cyc < 40) begin
      @(posedge clk); #1; cyc++;
      if (finish_store) got = 1'b1;
      rollback = (cyc == rb_at);
    end
    st_req = 1'b0; rollback = 1'b0;
    vectors++;
    if (!got) begin
      miscompares++; $display("FAIL store_timeout: op=%0d addr=%h no finish_store", op, addr);
    end else begin
      vectors++;
      if (cyc - 1 != n) begin
        miscompares++; $display("FAIL store_latency: got %0d edges expected %0d", cyc - 1, n);
      end
      vectors++;
      if (wr_log.size() - base != n) begin
        miscompares++; $display("FAIL store_count: %0d bus writes expected %0d", wr_log.size() - base, n);
      end else begin
        for (int i = 0; i < n; i++) begin
          a = addr + 32'(i);
          vectors++;
          if (wr_log[base + i] !== {a, data[8*i +: 8]}) begin
            miscompares++;
            $display("FAIL store_byte%0d: bus %h expected %h", i, wr_log[base + i], {a, data[8*i +: 8]});
          end
        end
      end
      vectors++;
      if (mem_wr !== 1'b0) begin
        miscompares++; $display("FAIL store_wr_release: mem_wr=%b expected 0", mem_wr);
      end
      if (addr[17:16] != 2'b11)
        for (int i = 0; i < n; i++) begin
          a = addr + 32'(i);
          ref_mem[a[15:0]] = data[8*i +: 8];
        end
      @(posedge clk); #1;
      vectors++;
      if (finish_store !== 1'b0) begin
        miscompares++; $display("FAIL store_pulse_width: finish_store=%b expected 0", finish_store);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b1; rollback = 1'b0; io_buffer_full = 1'b0;
    lsb_req = 1'b0; lsb_op = 6'd0; lsb_addr = 32'b0;
    st_req = 1'b0; st_op = 6'd0; st_addr = 32'b0; st_data = 32'b0;
    if_req = 1'b0; if_addr = 32'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (mem_a !== 32'b0) begin miscompares++; $display("FAIL reset_mem_a: %h expected 0", mem_a); end
    vectors++; if (mem_dout !== 8'b0) begin miscompares++; $display("FAIL reset_mem_dout: %h expected 0", mem_dout); end
    vectors++; if (mem_wr !== 1'b0) begin miscompares++; $display("FAIL reset_mem_wr: %b expected 0", mem_wr); end
    vectors++; if (mem_valid !== 1'b0) begin miscompares++; $display("FAIL reset_mem_valid: %b expected 0", mem_valid); end
    vectors++; if (mem_res !== 32'b0) begin miscompares++; $display("FAIL reset_mem_res: %h expected 0", mem_res); end
    vectors++; if (finish_store !== 1'b0) begin miscompares++; $display("FAIL reset_finish_store: %b expected 0", finish_store); end
    vectors++; if (if_valid !== 1'b0) begin miscompares++; $display("FAIL reset_if_valid: %b expected 0", if_valid); end
    vectors++; if (if_inst !== 32'b0) begin miscompares++; $display("FAIL reset_if_inst: %h expected 0", if_inst); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_fetch();
    logic [31:0] r;
    run_fetch(32'h100, r);
    vectors++;
    if (r !== 32'h1234_5678) begin miscompares++; $display("FAIL fetch_const: %h expected 12345678", r); end
  endtask

  task automatic test_loads();
    logic [31:0] r;
    poke(32'h103, 8'h80);
    run_load(OP_LB, 32'h103, 0, r);
    vectors++; if (r !== 32'hFFFF_FF80) begin miscompares++; $display("FAIL lb_const: %h expected ffffff80", r); end
    run_load(OP_LBU, 32'h103, 0, r);
    vectors++; if (r !== 32'h0000_0080) begin miscompares++; $display("FAIL lbu_const: %h expected 00000080", r); end
    run_load(OP_LH, 32'h100, 0, r);
    vectors++; if (r !== 32'h0000_5678) begin miscompares++; $display("FAIL lh_const: %h expected 00005678", r); end
    poke(32'h101, 8'h96);
    run_load(OP_LH, 32'h100, 0, r);
    run_load(OP_LHU, 32'h100, 0, r);
  endtask

  task automatic test_store();
    logic [31:0] r;
    run_store(OP_SW, 32'h200, 32'hDEAD_BEEF, -1);
    run_load(OP_LW, 32'h200, 0, r);
    vectors++; if (r !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL sw_readback: %h expected deadbeef", r); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] sdata, exp_if;
    int cyc, t_st, t_ld, t_if;
    sdata = $urandom;
    for (int i = 0; i < 4; i++) ref_mem[16'h300 + 16'(i)] = sdata[8*i +: 8];
    exp_if = ref_load(OP_LW, 32'h100);
    @(negedge clk);
    st_req = 1'b1; st_op = OP_SW; st_addr = 32'h300; st_data = sdata;
    lsb_req = 1'b1; lsb_op = OP_LW; lsb_addr = 32'h300;
    if_req = 1'b1; if_addr = 32'h100;
    cyc = 0; t_st = -1; t_ld = -1; t_if = -1;
    while ((st_req || lsb_req || if_req) && cyc < 60) begin
      @(posedge clk); #1; cyc++;
      if (finish_store) begin t_st = cyc; st_req = 1'b0; end
      if (mem_valid)    begin t_ld = cyc; lsb_req = 1'b0;
        vectors++;
        if (mem_res !== sdata) begin miscompares++; $display("FAIL b2b_load_data: %h expected %h", mem_res, sdata); end
      end
      if (if_valid)     begin t_if = cyc; if_req = 1'b0;
        vectors++;
        if (if_inst !== exp_if) begin miscompares++; $display("FAIL b2b_fetch_data: %h expected %h", if_inst, exp_if); end
      end
    end
    st_req = 1'b0; lsb_req = 1'b0; if_req = 1'b0;
    vectors++; if (t_st != 5) begin miscompares++; $display("FAIL b2b_store_time: cycle %0d expected 5", t_st); end
    vectors++; if (t_ld != 12) begin miscompares++; $display("FAIL b2b_load_time: cycle %0d expected 12", t_ld); end
    vectors++; if (t_if != 19) begin miscompares++; $display("FAIL b2b_fetch_time: cycle %0d expected 19", t_if); end
    @(posedge clk); #1;
  endtask

  task automatic test_io_block();
    logic [31:0] a_before;
    int cyc, t_st, t_if, io0;
    io0 = io_log.size();
    @(negedge clk);
    a_before = mem_a;
    io_buffer_full = 1'b1;
    st_req = 1'b1; st_op = OP_SB; st_addr = 32'h3_0000; st_data = 32'h0000_00A5;
    if_req = 1'b1; if_addr = 32'h100;
    repeat (3) begin
      @(posedge clk); #1;
      vectors++;
      if (mem_wr !== 1'b0 || mem_a !== a_before || if_valid !== 1'b0 || finish_store !== 1'b0) begin
        miscompares++;
        $display("FAIL io_blocked: mem_a=%h mem_wr=%b if_valid=%b finish_store=%b expected %h/0/0/0",
                 mem_a, mem_wr, if_valid, finish_store, a_before);
      end
    end
    @(negedge clk); io_buffer_full = 1'b0;
    cyc = 0; t_st = -1; t_if = -1;
    while ((st_req || if_req) && cyc < 40) begin
      @(posedge clk); #1; cyc++;
      if (finish_store) begin t_st = cyc; st_req = 1'b0; end
      if (if_valid)     begin t_if = cyc; if_req = 1'b0; end
    end
    st_req = 1'b0; if_req = 1'b0;
    vectors++; if (t_st != 2) begin miscompares++; $display("FAIL io_store_time: cycle %0d expected 2", t_st); end
    vectors++; if (t_if != 9) begin miscompares++; $display("FAIL io_fetch_time: cycle %0d expected 9", t_if); end
    vectors++;
    if (io_log.size() != io0 + 1) begin
      miscompares++; $display("FAIL io_write_count: %0d expected %0d", io_log.size(), io0 + 1);
    end else begin
      vectors++;
      if (io_log[io0] !== 8'hA5) begin miscompares++; $display("FAIL io_write_data: %h expected a5", io_log[io0]); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_rollback();
    logic [31:0] saved, a_before, r;
    int pulses;
    saved = mem_res;
    @(negedge clk); lsb_req = 1'b1; lsb_op = OP_LW; lsb_addr = 32'h200;
    repeat (3) begin @(posedge clk); #1; end
    rollback = 1'b1; lsb_req = 1'b0;
    @(posedge clk); #1; rollback = 1'b0;
    vectors++; if (mem_valid !== 1'b0) begin miscompares++; $display("FAIL rb_load_pulse: %b expected 0", mem_valid); end
    vectors++; if (mem_wr !== 1'b0) begin miscompares++; $display("FAIL rb_load_wr: %b expected 0", mem_wr); end
    pulses = 0;
    repeat (10) begin @(posedge clk); #1; if (mem_valid) pulses++; end
    vectors++; if (pulses != 0) begin miscompares++; $display("FAIL rb_load_late_pulse: %0d pulses expected 0", pulses); end
    vectors++; if (mem_res !== saved) begin miscompares++; $display("FAIL rb_load_res: %h expected %h", mem_res, saved); end

    // Rollback in IDLE: a load must not be accepted that cycle.
    @(negedge clk); a_before = mem_a; rollback = 1'b1; lsb_req = 1'b1; lsb_op = OP_LB; lsb_addr = 32'h1234;
    repeat (2) begin
      @(posedge clk); #1;
      vectors++;
      if (mem_a !== a_before) begin miscompares++; $display("FAIL rb_idle_accept: mem_a=%h expected %h", mem_a, a_before); end
    end
    rollback = 1'b0; lsb_req = 1'b0;
    repeat (2) @(posedge clk);

    run_store(OP_SW, 32'h210, 32'hCAFE_F00D, 2);
    run_load(OP_LW, 32'h210, 0, r);
    vectors++; if (r !== 32'hCAFE_F00D) begin miscompares++; $display("FAIL rb_store_readback: %h expected cafef00d", r); end
  endtask

  task automatic test_rdy_stall();
    logic [31:0] r;
    run_load(OP_LW, 32'h200, 2, r);
  endtask

  task automatic test_reset_mid();
    int pulses;
    @(negedge clk); lsb_req = 1'b1; lsb_op = OP_LW; lsb_addr = 32'h100;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; lsb_req = 1'b0;
    vectors++; if (mem_a !== 32'b0) begin miscompares++; $display("FAIL rstmid_mem_a: %h expected 0", mem_a); end
    pulses = 0;
    repeat (8) begin @(posedge clk); #1; if (mem_valid) pulses++; end
    vectors++; if (pulses != 0) begin miscompares++; $display("FAIL rstmid_pulse: %0d pulses expected 0", pulses); end
    vectors++; if (mem_res !== 32'b0) begin miscompares++; $display("FAIL rstmid_res: %h expected 0", mem_res); end
  endtask

  task automatic test_random();
    logic [31:0] r, addr;
    op_t lops [5];
    op_t sops [3];
    lops = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    sops = '{OP_SB, OP_SH, OP_SW};
    for (int it = 0; it < 40; it++) begin
      addr = 32'h1000 + 32'($urandom_range(0, 255));
      case ($urandom_range(0, 2))
        0:       run_store(sops[$urandom_range(0, 2)], addr, $urandom, -1);
        1:       run_load(lops[$urandom_range(0, 4)], addr, 0, r);
        default: run_fetch(addr, r);
      endcase
    end
    run_load(OP_LW, 32'hFFFF_FFFE, 0, r);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      ram[i]     = 8'($urandom);
      ref_mem[i] = ram[i];
    end
    poke(32'h100, 8'h78); poke(32'h101, 8'h56); poke(32'h102, 8'h34); poke(32'h103, 8'h12);

    test_reset();
    test_fetch();
    test_loads();
    test_store();
    test_back_to_back();
    test_io_block();
    test_rollback();
    test_rdy_stall();
    test_reset_mid();
    test_random();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
